lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_gen_if.sv | 25 ++
 rtl/lcd_timing_gen.sv | 85 ++++++++
 tb/tb_lcd_timing_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: pattern controls in, panel sync/colour out.
// The host (master) drives controls; the generator (slave) drives the panel side.
interface lcd_timing_gen_if #(parameter int CW = 6);
    logic            enable_i;
    logic [1:0]      mode_i;
    logic [3*CW-1:0] solid_rgb_i;
    logic [3*CW-1:0] ext_rgb_i;
    logic            pix_req_o;
    logic            hsync_o;
    logic            vsync_o;
    logic            de_o;
    logic            frame_start_o;
    logic [CW-1:0]   red_o;
    logic [CW-1:0]   green_o;
    logic [CW-1:0]   blue_o;

    modport master (
        output enable_i, mode_i, solid_rgb_i, ext_rgb_i,
        input  pix_req_o, hsync_o, vsync_o, de_o, frame_start_o, red_o, green_o, blue_o
    );
    modport slave (
        input  enable_i, mode_i, solid_rgb_i, ext_rgb_i,
        output pix_req_o, hsync_o, vsync_o, de_o, frame_start_o, red_o, green_o, blue_o
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD panel sync/DE generator with solid, bar, XOR and external patterns.
// Define LCD_TIMING_GEN_SCROLL_EN to scroll the XOR texture by one step per frame.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 1366,
    parameter int H_BLANK  = 169,
    parameter int V_ACTIVE = 768,
    parameter int V_BLANK  = 12,
    parameter int CW       = 6,
    parameter int CNT_W    = 11
) (
    input logic             clk,
    input logic             rst_n,
    lcd_timing_gen_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [1:0]       mode_q, mode_d;
    logic [3*CW-1:0]  rgb_q, rgb_d;
    logic             de_q, hs_q, vs_q, req_q, fs_q;
    logic             active, nxt_active, h_wrap;
    logic [2:0]       bar;
    logic [5:0]       off, tex;

    always_comb begin
        h_wrap     = h_q == CNT_W'(H_TOTAL - 1);
        h_d        = h_wrap ? '0 : h_q + 1'b1;
        v_d        = !h_wrap ? v_q : v_q == CNT_W'(V_TOTAL - 1) ? '0 : v_q + 1'b1;
        // the frame's first pixel already uses the newly latched mode
        mode_d     = (h_q == '0 && v_q == '0) ? bus.mode_i : mode_q;
        active     = h_q < CNT_W'(H_ACTIVE) && v_q < CNT_W'(V_ACTIVE);
        nxt_active = h_d < CNT_W'(H_ACTIVE) && v_d < CNT_W'(V_ACTIVE);
        bar        = 3'(({3'b000, h_q} << 3) / (CNT_W + 3)'(H_ACTIVE));
        tex        = (h_q[5:0] + off) ^ (v_q[5:0] + off);
        rgb_d      = !active ? '0
                   : mode_d == 2'd0 ? bus.solid_rgb_i
                   : mode_d == 2'd1 ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}}
                   : mode_d == 2'd2 ? {CW'({tex, 1'b0}), CW'({tex, 2'b00}),
                                       CW'({2'b00, tex} + {1'b0, tex, 1'b0})}
                   : bus.ext_rgb_i;
    end

`ifdef LCD_TIMING_GEN_SCROLL_EN
    logic [5:0] off_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            off_q <= '0;
        else if (bus.enable_i && h_wrap && v_q == CNT_W'(V_TOTAL - 1))
            off_q <= off_q - 1'b1;
    assign off = off_q;
`else
    assign off = '0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= '0;
            rgb_q  <= '0;
            de_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            req_q  <= 1'b0;
            fs_q   <= 1'b0;
        end else if (bus.enable_i) begin
            h_q    <= h_d;
            v_q    <= v_d;
            mode_q <= mode_d;
            rgb_q  <= rgb_d;
            de_q   <= active;
            hs_q   <= h_q < CNT_W'(H_ACTIVE);
            vs_q   <= v_q < CNT_W'(V_ACTIVE);
            req_q  <= nxt_active;
            fs_q   <= h_q == '0 && v_q == '0;
        end

    assign bus.de_o          = de_q;
    assign bus.hsync_o       = hs_q;
    assign bus.vsync_o       = vs_q;
    assign bus.pix_req_o     = req_q;
    assign bus.frame_start_o = fs_q;
    assign {bus.red_o, bus.green_o, bus.blue_o} = rgb_q;
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: random enable/mode/ext/reset stimulus against a frame-position model.
// The model tracks a flat pixel index within the frame and derives all outputs arithmetically.
module tb_lcd_timing_gen;
    localparam int HA = 8, HB = 4, VA = 4, VB = 2, CW = 6;
    localparam int HT = HA + HB, VT = VA + VB, FT = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, failures = 0;

    int              pos, mode_m, off;
    logic            e_de, e_hs, e_vs, e_fs, e_req;
    logic [3*CW-1:0] e_rgb;

    lcd_timing_gen_if #(.CW(CW)) bus ();

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .CW(CW), .CNT_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s pos=%0d got=%0h exp=%0h", tag, pos, got, exp);
        end
    endtask

    function automatic bit vis(input int p);
        return (p % HT) < HA && (p / HT) < VA;
    endfunction

    function automatic logic [3*CW-1:0] pattern(input int m, input int h, input int v, input int o,
                                                input logic [3*CW-1:0] solid, input logic [3*CW-1:0] ext);
        int b, t;
        b = h * 8 / HA;
        t = ((h + o) % 64) ^ ((v + o) % 64);
        if (m == 0) return solid;
        if (m == 1) return {6'((b / 4) % 2 * 63), 6'((b / 2) % 2 * 63), 6'(b % 2 * 63)};
        if (m == 2) return {6'((t * 2) % 64), 6'((t * 4) % 64), 6'((t * 3) % 64)};
        return ext;
    endfunction

    task automatic model_reset();
        pos = 0; mode_m = 0; off = 0;
        e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_req = 0; e_rgb = '0;
    endtask

    task automatic model_step();
        if (!bus.enable_i) return;
        if (pos == 0) mode_m = int'(bus.mode_i);
        e_de  = vis(pos);
        e_hs  = (pos % HT) < HA;
        e_vs  = (pos / HT) < VA;
        e_fs  = pos == 0;
        e_req = vis((pos + 1) % FT);
        e_rgb = vis(pos) ? pattern(mode_m, pos % HT, pos / HT, off, bus.solid_rgb_i, bus.ext_rgb_i) : '0;
`ifdef LCD_TIMING_GEN_SCROLL_EN
        if (pos == FT - 1) off = (off + 63) % 64;
`endif
        pos = (pos + 1) % FT;
    endtask

    task automatic compare();
        check("de", 32'(bus.de_o), 32'(e_de));
        check("hsync", 32'(bus.hsync_o), 32'(e_hs));
        check("vsync", 32'(bus.vsync_o), 32'(e_vs));
        check("frame_start", 32'(bus.frame_start_o), 32'(e_fs));
        check("pix_req", 32'(bus.pix_req_o), 32'(e_req));
        check("rgb", 32'({bus.red_o, bus.green_o, bus.blue_o}), 32'(e_rgb));
    endtask

    initial begin
        bus.enable_i    = 1'b1;
        bus.mode_i      = 2'd0;
        bus.solid_rgb_i = 18'h2A5C3;
        bus.ext_rgb_i   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        compare();
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) begin
                @(negedge clk);
                compare();
            end
            if (rst_n && c > 0 && $urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare();
            end else
                rst_n = 1'b1;
            bus.enable_i  = $urandom_range(0, 99) < 85;
            bus.ext_rgb_i = 18'($urandom);
            if ($urandom_range(0, 59) == 0) bus.mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) bus.solid_rgb_i = 18'($urandom);
            if (rst_n) model_step();
        end
        @(negedge clk);
        compare();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
